// File: rtl/dram_init_sequencer.sv
// DRAM power-up / initialisation sequencer: reset pins, mode register
// writes per rank, ZQ calibration, then DLL lock wait.
package dram_init_pkg;
  typedef enum logic [1:0] {
    CMD_NOP  = 2'd0,
    CMD_LMR  = 2'd1,
    CMD_ZQCL = 2'd2
  } command_t;
endpackage

module dram_init_sequencer
  import dram_init_pkg::*;
#(
  parameter int          NUM_RANK = 2,
  parameter int          NUM_MR   = 4,
  parameter logic [15:0] T_PWRUP  = 16'd200,
  parameter logic [15:0] T_RST    = 16'd500,
  parameter logic [15:0] T_XPR    = 16'd5,
  parameter logic [15:0] T_MRD    = 16'd4,
  parameter logic [15:0] T_MOD    = 16'd12,
  parameter logic [15:0] T_ZQINIT = 16'd512,
  parameter logic [15:0] T_DLLK   = 16'd512,
  parameter int          CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 reinit_req_i,
  input  logic [NUM_MR*16-1:0] mr_data_i,
  input  logic                 cmd_ready_i,
  output logic                 cmd_valid_o,
  output command_t             cmd_o,
  output logic [1:0]           cmd_rank_o,
  output logic [1:0]           cmd_ba_o,
  output logic [15:0]          cmd_addr_o,
  output logic                 dram_rst_n_o,
  output logic                 cke_o,
  output logic                 init_done_o
);

  typedef enum logic [3:0] {
    FSM_POWER_UP,
    FSM_RESET_PROCEDURE,
    FSM_WAIT_TXPR,
    FSM_LMR,
    FSM_LMR_WAIT,
    FSM_ZQ,
    FSM_ZQ_WAIT,
    FSM_WAIT_TDLLK,
    FSM_INIT_DONE
  } state_t;

  localparam logic [1:0] MR_LAST   = 2'(NUM_MR - 1);
  localparam logic [1:0] RANK_LAST = 2'(NUM_RANK - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, lim;
  logic [1:0]       rank_q, rank_d;
  logic [1:0]       mr_q, mr_d;
  logic             cmd_valid_q;
  command_t         cmd_q;
  logic [1:0]       cmd_rank_q, cmd_ba_q;
  logic [15:0]      cmd_addr_q, mr_sel;
  logic             dram_rst_n_q, cke_q, init_done_q;
  logic             cnt_done, hs, issue_d;

  assign hs       = cmd_valid_q & cmd_ready_i;
  assign cnt_done = (cnt_q == lim);
  assign issue_d  = (state_d == FSM_LMR) || (state_d == FSM_ZQ);

  always_comb begin
    lim = '0;
    unique case (state_q)
      FSM_POWER_UP:        lim = CNT_W'(T_PWRUP - 16'd1);
      FSM_RESET_PROCEDURE: lim = CNT_W'(T_RST - 16'd1);
      FSM_WAIT_TXPR:       lim = CNT_W'(T_XPR - 16'd1);
      FSM_LMR_WAIT:        lim = (mr_q == 2'd0) ? CNT_W'(T_MOD - 16'd1)
                                                : CNT_W'(T_MRD - 16'd1);
      FSM_ZQ_WAIT:         lim = CNT_W'(T_ZQINIT - 16'd1);
      FSM_WAIT_TDLLK:      lim = CNT_W'(T_DLLK - 16'd1);
      default:             lim = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    rank_d  = rank_q;
    mr_d    = mr_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    if (reinit_req_i && state_q != FSM_POWER_UP) begin
      state_d = FSM_RESET_PROCEDURE;
      cnt_d   = '0;
      rank_d  = '0;
      mr_d    = '0;
    end else begin
      unique case (state_q)
        FSM_POWER_UP:
          if (cnt_done) state_d = FSM_RESET_PROCEDURE;
        FSM_RESET_PROCEDURE:
          if (cnt_done) state_d = FSM_WAIT_TXPR;
        FSM_WAIT_TXPR:
          if (cnt_done) begin
            state_d = FSM_LMR;
            rank_d  = '0;
            mr_d    = MR_LAST;
          end
        FSM_LMR:
          if (hs) state_d = FSM_LMR_WAIT;
        FSM_LMR_WAIT:
          if (cnt_done) begin
            if (mr_q != 2'd0) begin
              mr_d    = mr_q - 2'd1;
              state_d = FSM_LMR;
            end else if (rank_q != RANK_LAST) begin
              rank_d  = rank_q + 2'd1;
              mr_d    = MR_LAST;
              state_d = FSM_LMR;
            end else begin
              rank_d  = '0;
              state_d = FSM_ZQ;
            end
          end
        FSM_ZQ:
          if (hs) state_d = FSM_ZQ_WAIT;
        FSM_ZQ_WAIT:
          if (cnt_done) begin
            if (rank_q != RANK_LAST) begin
              rank_d  = rank_q + 2'd1;
              state_d = FSM_ZQ;
            end else begin
              state_d = FSM_WAIT_TDLLK;
            end
          end
        FSM_WAIT_TDLLK:
          if (cnt_done) state_d = FSM_INIT_DONE;
        default: state_d = state_q;
      endcase
    end
    if (state_d != state_q) cnt_d = '0;
  end

  always_comb begin
    mr_sel = '0;
    for (int k = 0; k < NUM_MR; k++)
      if (mr_d == 2'(k)) mr_sel = mr_data_i[16*k +: 16];
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FSM_POWER_UP;
      cnt_q        <= '0;
      rank_q       <= '0;
      mr_q         <= MR_LAST;
      cmd_valid_q  <= 1'b0;
      cmd_q        <= CMD_NOP;
      cmd_rank_q   <= '0;
      cmd_ba_q     <= '0;
      cmd_addr_q   <= '0;
      dram_rst_n_q <= 1'b0;
      cke_q        <= 1'b0;
      init_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rank_q       <= rank_d;
      mr_q         <= mr_d;
      cmd_valid_q  <= issue_d;
      cmd_rank_q   <= issue_d ? rank_d : 2'd0;
      cmd_ba_q     <= (state_d == FSM_LMR) ? mr_d : 2'd0;
      if (state_d == FSM_LMR) begin
        cmd_q <= CMD_LMR;
        if (state_q != FSM_LMR) cmd_addr_q <= mr_sel;
      end else if (state_d == FSM_ZQ) begin
        cmd_q      <= CMD_ZQCL;
        cmd_addr_q <= 16'h0400;
      end else begin
        cmd_q      <= CMD_NOP;
        cmd_addr_q <= '0;
      end
      dram_rst_n_q <= (state_d != FSM_POWER_UP);
      cke_q        <= (state_d != FSM_POWER_UP) &&
                      (state_d != FSM_RESET_PROCEDURE);
      init_done_q  <= (state_d == FSM_INIT_DONE);
    end
  end

  assign cmd_valid_o  = cmd_valid_q;
  assign cmd_o        = cmd_q;
  assign cmd_rank_o   = cmd_rank_q;
  assign cmd_ba_o     = cmd_ba_q;
  assign cmd_addr_o   = cmd_addr_q;
  assign dram_rst_n_o = dram_rst_n_q;
  assign cke_o        = cke_q;
  assign init_done_o  = init_done_q;

endmodule

// File: doc/dram_init_sequencer.md
DRAM_INIT_SEQUENCER -- requirements
Module: dram_init_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_RANK, default 2, giving the number of ranks initialised in sequence (legal 1..4).
REQ-002 The block SHALL have parameter NUM_MR, default 4, giving the number of mode registers written per rank (legal 1..4).
REQ-003 The block SHALL have delay parameters T_PWRUP=16'd200, T_RST=16'd500, T_XPR=16'd5, T_MRD=16'd4, T_MOD=16'd12, T_ZQINIT=16'd512 and T_DLLK=16'd512; each is a wait length in clk cycles and each SHALL be at least 1.
REQ-004 The block SHALL have parameter CNT_W, default 16, giving the delay counter width.
REQ-005 clk  input  1  sole clock; every register updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 reinit_req_i  input  1  single-cycle pulse that restarts initialisation from FSM_RESET_PROCEDURE.
REQ-008 mr_data_i  input  NUM_MR*16  value for MR k is bits [16k+15:16k]; it is sampled when the LMR command is issued.
REQ-009 cmd_ready_i  input  1  command bus accepts the current command.
REQ-010 cmd_valid_o  output  1  the command is valid.
REQ-011 cmd_o  output  command_t  the command, one of CMD_NOP, CMD_LMR or CMD_ZQCL.
REQ-012 cmd_rank_o  output  2  target rank.
REQ-013 cmd_ba_o  output  2  mode register index.
REQ-014 cmd_addr_o  output  16  mode register value.
REQ-015 dram_rst_n_o  output  1  DRAM RESET# pin.
REQ-016 cke_o  output  1  DRAM CKE pin.
REQ-017 init_done_o  output  1  initialisation complete.
REQ-018 All outputs SHALL be driven directly from flops.

Function
REQ-019 The FSM states SHALL be FSM_POWER_UP, FSM_RESET_PROCEDURE, FSM_WAIT_TXPR, FSM_LMR, FSM_LMR_WAIT, FSM_ZQ, FSM_ZQ_WAIT, FSM_WAIT_TDLLK and FSM_INIT_DONE.
REQ-020 Each wait state with delay T SHALL last exactly T cycles: the counter counts 0..T-1 and the state exits on the cycle the counter equals T-1, with the counter cleared on every state change.
REQ-021 FSM_POWER_UP SHALL drive dram_rst_n_o=0 and cke_o=0, and after T_PWRUP cycles go to FSM_RESET_PROCEDURE.
REQ-022 FSM_RESET_PROCEDURE SHALL drive dram_rst_n_o=1 and cke_o=0, and after T_RST cycles go to FSM_WAIT_TXPR.
REQ-023 cke_o SHALL be 1 in FSM_WAIT_TXPR and in every later state; after T_XPR cycles the FSM goes to FSM_LMR with rank=0 and mr=NUM_MR-1.
REQ-024 FSM_LMR SHALL hold cmd_valid_o=1, cmd_o=CMD_LMR, cmd_rank_o=rank, cmd_ba_o=mr and cmd_addr_o=MR[mr] until a cycle where cmd_valid_o and cmd_ready_i are both 1.
REQ-025 On that handshake cycle the FSM SHALL go to FSM_LMR_WAIT, and on the following cycle cmd_valid_o SHALL be 0 and cmd_o SHALL be CMD_NOP.
REQ-026 Command fields SHALL stay stable while cmd_valid_o=1 and cmd_ready_i=0.
REQ-027 FSM_LMR_WAIT SHALL wait T_MRD cycles, or T_MOD cycles when mr==0 (the last MR of the rank).
REQ-028 At the end of FSM_LMR_WAIT: if mr>0, mr decrements and the FSM goes to FSM_LMR; else if rank<NUM_RANK-1, rank increments, mr reloads to NUM_MR-1 and the FSM goes to FSM_LMR; else rank clears to 0 and the FSM goes to FSM_ZQ.
REQ-029 FSM_ZQ SHALL issue CMD_ZQCL to the current rank with cmd_addr_o bit 10 = 1 and all other address bits 0, using the same handshake as FSM_LMR, then go to FSM_ZQ_WAIT.
REQ-030 FSM_ZQ_WAIT SHALL wait T_ZQINIT cycles, then go to FSM_ZQ with the next rank, or to FSM_WAIT_TDLLK after the last rank.
REQ-031 FSM_WAIT_TDLLK SHALL wait T_DLLK cycles, then go to FSM_INIT_DONE.
REQ-032 init_done_o SHALL be 1 from the first cycle in FSM_INIT_DONE and stay 1 while the FSM remains there.
REQ-033 cmd_valid_o SHALL be 0 and cmd_o SHALL be CMD_NOP in every state except FSM_LMR and FSM_ZQ.
REQ-034 cmd_rank_o and cmd_ba_o SHALL be 0 outside FSM_LMR and FSM_ZQ.
REQ-035 The total number of commands accepted SHALL be NUM_RANK*(NUM_MR+1).
REQ-036 reinit_req_i in any state other than FSM_POWER_UP SHALL, on the next cycle, enter FSM_RESET_PROCEDURE with counter, rank and mr cleared, init_done_o=0 and cmd_valid_o=0, even mid-handshake; reinit_req_i in FSM_POWER_UP SHALL be ignored.
REQ-037 If rst and reinit_req_i are both 1 in the same cycle, rst SHALL win.
REQ-038 The counter SHALL never wrap: it saturates at its maximum, which is unreachable for legal parameters.

Reset
REQ-039 When rst=1 at a clk edge, the block SHALL load state=FSM_POWER_UP, counter=0, rank=0, mr=NUM_MR-1, cmd_valid_o=0, cmd_o=CMD_NOP, cmd_rank_o=0, cmd_ba_o=0, cmd_addr_o=0, dram_rst_n_o=0, cke_o=0 and init_done_o=0.
REQ-040 Reset SHALL take effect from any state, including mid-handshake.

Verification
REQ-041 NUM_RANK=1, NUM_MR=4, all T=4, cmd_ready_i tied to 1 -> LMR commands go out with BA order 3,2,1,0 carrying mr_data_i fields, then one ZQCL, and init_done_o rises at cycle 4+4+4+(4*(1+4)-1... exact count checked against the model).
REQ-042 NUM_RANK=2, cmd_ready_i low for 3 cycles on each command -> each command is held stable for 4 cycles, 10 commands are accepted in total, and the rank-0 commands all precede the rank-1 commands.
REQ-043 T_PWRUP=3, T_RST=5 -> dram_rst_n_o rises exactly 3 cycles after reset release, and cke_o rises exactly 5 cycles after that.
REQ-044 reinit_req_i pulsed while in FSM_LMR_WAIT for rank 1 -> next cycle dram_rst_n_o=1, cke_o=0, init_done_o=0, and the full sequence reruns from rank 0, MR NUM_MR-1.
REQ-045 rst asserted during FSM_ZQ with cmd_valid_o=1 -> next cycle all outputs equal their reset values, and no handshake occurs.
REQ-046 rst and reinit_req_i asserted in the same cycle -> the state is FSM_POWER_UP on the next cycle.
